// File: rtl/sobel_pkg.sv
// Shared constants and types for the Sobel edge-magnitude block.
// The gradient width is always the pixel width plus three guard bits.
package sobel_pkg;

  localparam int DEF_WIDTH  = 12;
  localparam int GRAD_EXTRA = 3;
  localparam int GRAD_W     = DEF_WIDTH + GRAD_EXTRA;
  localparam logic [DEF_WIDTH-1:0] SAT_MAX = '1;

  // Window indexed [row][col]; row 0 = top, col 0 = oldest.
  typedef logic [2:0][2:0][DEF_WIDTH-1:0] window_t;

  function automatic int grad_width(input int w);
    return w + GRAD_EXTRA;
  endfunction

endpackage

// File: rtl/sobel_kernel.sv
// Sobel gradient (stage 2) and saturated magnitude (stage 3) pipeline.
// Optional binarisation against thresh when SOBEL_THRESH_EN is defined.
module sobel_kernel
  import sobel_pkg::*;
#(
  parameter int WIDTH = 12
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic [2:0][2:0][WIDTH-1:0]  win,
  input  logic                        border,
  input  logic                        valid,
  input  logic [WIDTH-1:0]            thresh,
  output logic [WIDTH-1:0]            out_pix,
  output logic                        out_valid
);

  localparam int GW = grad_width(WIDTH);

  function automatic logic signed [GW-1:0] ext(input logic [WIDTH-1:0] p);
    return $signed({{GRAD_EXTRA{1'b0}}, p});
  endfunction

  logic signed [GW-1:0] gx_next, gy_next;
  logic signed [GW-1:0] gx_reg, gy_reg;
  logic                 valid2_reg, border2_reg;
  logic [GW-1:0]        abs_x, abs_y, mag_sum;
  logic [WIDTH-1:0]     mag_sat, pix_calc, pix_next;

  always_comb begin
    gx_next = (ext(win[0][2]) + ext(win[1][2]) + ext(win[1][2]) + ext(win[2][2]))
            - (ext(win[0][0]) + ext(win[1][0]) + ext(win[1][0]) + ext(win[2][0]));
    gy_next = (ext(win[2][0]) + ext(win[2][1]) + ext(win[2][1]) + ext(win[2][2]))
            - (ext(win[0][0]) + ext(win[0][1]) + ext(win[0][1]) + ext(win[0][2]));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gx_reg      <= '0;
      gy_reg      <= '0;
      valid2_reg  <= 1'b0;
      border2_reg <= 1'b0;
    end else if (enable) begin
      gx_reg      <= gx_next;
      gy_reg      <= gy_next;
      valid2_reg  <= valid;
      border2_reg <= border;
    end
  end

  // |Gx|+|Gy| never exceeds 8*(2^WIDTH-1), so GW unsigned bits cannot overflow.
  always_comb begin
    abs_x   = gx_reg[GW-1] ? GW'(-gx_reg) : GW'(gx_reg);
    abs_y   = gy_reg[GW-1] ? GW'(-gy_reg) : GW'(gy_reg);
    mag_sum = abs_x + abs_y;
    mag_sat = (mag_sum[GW-1:WIDTH] != '0) ? '1 : mag_sum[WIDTH-1:0];
  end

`ifdef SOBEL_THRESH_EN
  assign pix_calc = (mag_sat >= thresh) ? '1 : '0;
`else
  logic unused_thresh;
  assign unused_thresh = ^thresh;
  assign pix_calc      = mag_sat;
`endif

  assign pix_next = (border2_reg || !valid2_reg) ? '0 : pix_calc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_pix   <= '0;
      out_valid <= 1'b0;
    end else if (enable) begin
      out_pix   <= pix_next;
      out_valid <= valid2_reg;
    end
  end

endmodule

// File: rtl/sobel_window.sv
// 3x3 window shift register, column counter and border flag feeding the
// Sobel kernel. Build option: SOBEL_THRESH_EN (binary edge output).
module sobel_window
  import sobel_pkg::*;
#(
  parameter int WIDTH = 12,
  parameter int IMG_W = 640
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [WIDTH-1:0] row_top,
  input  logic [WIDTH-1:0] row_mid,
  input  logic [WIDTH-1:0] row_bot,
  input  logic             in_valid,
  input  logic             in_sol,
  input  logic [WIDTH-1:0] thresh,
  output logic [WIDTH-1:0] out_pix,
  output logic             out_valid
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);

  logic [2:0][WIDTH-1:0]        taps;
  logic [2:0][2:0][WIDTH-1:0]   win_reg;
  logic [CW-1:0]                col_reg, col_next;
  logic                         valid_reg, border_reg;

  assign taps = {row_bot, row_mid, row_top};

  // A start-of-line marker resyncs the counter even mid-line.
  always_comb begin
    col_next = col_reg + CW'(1);
    if (in_sol || col_reg == COL_LAST) begin
      col_next = '0;
    end
  end

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_row
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          win_reg[gi] <= '0;
        end else if (enable) begin
          win_reg[gi][0] <= win_reg[gi][1];
          win_reg[gi][1] <= win_reg[gi][2];
          win_reg[gi][2] <= taps[gi];
        end
      end
    end
  endgenerate

  // Border marks windows whose newest column is 0 or 1 (straddling line start).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_reg    <= '0;
      valid_reg  <= 1'b0;
      border_reg <= 1'b0;
    end else if (enable) begin
      col_reg    <= col_next;
      valid_reg  <= in_valid;
      border_reg <= (col_next < CW'(2));
    end
  end

  sobel_kernel #(
    .WIDTH(WIDTH)
  ) u_kernel (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .win      (win_reg),
    .border   (border_reg),
    .valid    (valid_reg),
    .thresh   (thresh),
    .out_pix  (out_pix),
    .out_valid(out_valid)
  );

endmodule

// File: tb/tb_sobel_window.sv
// Directed test of sobel_window with WIDTH=12, IMG_W=8; expected pixels are
// hand-derived per pattern and column, with a 2-entry pipeline queue.
module tb_sobel_window;

  localparam int WIDTH = 12;
  localparam int IMG_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             enable = 1'b0;
  logic [WIDTH-1:0] row_top = '0, row_mid = '0, row_bot = '0;
  logic             in_valid = 1'b0, in_sol = 1'b0;
  logic [WIDTH-1:0] thresh = 12'h080;
  logic [WIDTH-1:0] out_pix;
  logic             out_valid;

  int total = 0;
  int bad   = 0;
  int col_m = 0;
  int exp_q[$];
  bit val_q[$];

  sobel_window #(.WIDTH(WIDTH), .IMG_W(IMG_W)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .row_top(row_top), .row_mid(row_mid), .row_bot(row_bot),
    .in_valid(in_valid), .in_sol(in_sol), .thresh(thresh),
    .out_pix(out_pix), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Patterns: 0 flat 0x800, 1 vertical step at col 4, 2 horizontal edge, 3 junk.
  function automatic int pat_mag(input int pat, input int c);
    case (pat)
      1:       return (c == 4 || c == 5) ? 'hFFF : 0;
      2:       return 'h080;
      default: return 0;
    endcase
  endfunction

  function automatic int apply_out(input int e);
    if (e < 0) return 0;
`ifdef SOBEL_THRESH_EN
    return (e >= int'(thresh)) ? 'hFFF : 0;
`else
    return e;
`endif
  endfunction

  task automatic prefill();
    exp_q.delete();
    val_q.delete();
    repeat (2) begin
      exp_q.push_back(-1);
      val_q.push_back(1'b0);
    end
  endtask

  task automatic push(input int pat, input bit vld, input bit sol, input int stall);
    int e;
    bit ev;
    col_m = sol ? 0 : ((col_m == IMG_W - 1) ? 0 : col_m + 1);
    case (pat)
      0: begin row_top = 12'h800; row_mid = 12'h800; row_bot = 12'h800; end
      1: begin
        row_top = (col_m < 4) ? 12'h000 : 12'hFFF;
        row_mid = row_top;
        row_bot = row_top;
      end
      2: begin row_top = 12'h000; row_mid = 12'h010; row_bot = 12'h020; end
      default: begin
        row_top = WIDTH'($urandom); row_mid = WIDTH'($urandom); row_bot = WIDTH'($urandom);
      end
    endcase
    in_valid = vld;
    in_sol   = sol;
    enable   = 1'b1;
    @(posedge clk);
    #1;
    enable = 1'b0;
    in_sol = 1'b0;
    exp_q.push_back((!vld || col_m < 2) ? -1 : pat_mag(pat, col_m));
    val_q.push_back(vld);
    e  = exp_q.pop_front();
    ev = val_q.pop_front();
    $display("beat pat=%0d col=%0d out_pix=%03h out_valid=%0b", pat, col_m, out_pix, out_valid);
    check("pix", out_pix, apply_out(e));
    check("valid", out_valid, ev);
    for (int i = 0; i < stall; i++) begin
      row_top = WIDTH'($urandom);
      row_mid = WIDTH'($urandom);
      row_bot = WIDTH'($urandom);
      in_sol  = 1'($urandom);
      @(posedge clk);
      #1;
      in_sol = 1'b0;
      check("hold_pix", out_pix, apply_out(e));
      check("hold_valid", out_valid, ev);
    end
  endtask

  task automatic run_line(input int pat, input bit vld, input int stall_max);
    for (int c = 0; c < IMG_W; c++) begin
      push(pat, vld, c == 0, (stall_max > 0) ? $urandom_range(0, stall_max) : 0);
    end
  endtask

  initial begin
    // Reset and idle
    #12;
    check("rst_pix", out_pix, 0);
    check("rst_valid", out_valid, 0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_pix", out_pix, 0);
      check("idle_valid", out_valid, 0);
    end
    prefill();
    col_m = 0;

    run_line(0, 1'b1, 0);       // flat field
    run_line(1, 1'b1, 0);       // vertical step
    run_line(2, 1'b1, 0);       // horizontal edge, unsaturated
    run_line(3, 1'b0, 0);       // invalid windows
    run_line(1, 1'b1, 0);
    run_line(1, 1'b1, 3);       // stalls must not change the sequence
    run_line(2, 1'b1, 2);

    // Line resync: sol arrives at column 5 of a partial line
    for (int c = 0; c < 5; c++) push(2, 1'b1, c == 0, 0);
    run_line(2, 1'b1, 0);

    // Asynchronous reset mid-line
    for (int c = 0; c < 6; c++) push(2, 1'b1, c == 0, 0);
    check("pre_rst_valid", out_valid, 1);
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_pix", out_pix, 0);
    check("mid_rst_valid", out_valid, 0);
    @(negedge clk);
    rst = 1'b1;
    prefill();
    col_m = 0;
    run_line(2, 1'b1, 0);
    run_line(1, 1'b1, 0);

    // Threshold boundary (magnitude 0x080)
    thresh = 12'h080;
    run_line(2, 1'b1, 0);
    thresh = 12'h081;
    run_line(2, 1'b1, 0);
    run_line(2, 1'b1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
